// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the word-copy bus initiator.
//   state_t    : copy engine states
//   BE_FULL    : byte enables driven for every word transfer
//   WORD_BYTES : address increment per copied word
package bus_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        NEXT,
        DONE
    } state_t;

    localparam logic [3:0]  BE_FULL    = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/bus_copy_master_watchdog.sv
// Per-wait cycle counter for the copy engine.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   clear           : restart the count (next cycle starts from 0)
//   enable          : the engine is waiting on the bus this cycle
//   expired         : this is the last allowed wait cycle (count == TIMEOUT-1)
module bus_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT-1 so a missed clear can never wrap back to a
    // fresh-looking count.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_copy_master.sv
// Word-copy DMA initiator on the 32-bit split-request bus. Reads one source
// word, writes it to the destination, repeats for len_bi words. One bus
// transaction outstanding at a time; every wait is bounded by a watchdog.
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   start_i, abort_i         : command strobe (IDLE only), stop at word boundary
//   src_addr_bi, dst_addr_bi : byte addresses, low two bits ignored
//   len_bi                   : word count
//   busy_o, done_o, err_o    : status; err_o is a sticky timeout flag
//   words_bo                 : words fully written so far
//   bus_*                    : request side (req/we/addr/be/wdata) and
//                              response side (ack/resp/rdata)
module bus_copy_master
    import bus_copy_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_bi,
    input  logic [31:0]      dst_addr_bi,
    input  logic [LEN_W-1:0] len_bi,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_bo,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [31:0]      bus_addr_bo,
    output logic [3:0]       bus_be_bo,
    output logic [31:0]      bus_wdata_bo,
    input  logic             bus_ack_i,
    input  logic             bus_resp_i,
    input  logic [31:0]      bus_rdata_bi
);

    state_t           state_q, state_d;
    logic [31:0]      src_q, dst_q, data_q;
    logic [LEN_W-1:0] len_q, words_q;
    logic             err_q;

    logic capture, advance, set_err, accept;
    logic wd_clear, wd_enable, wd_expired;

    assign accept = (state_q == IDLE) && start_i;

    // Every entry into a waiting state is a state change, so clearing on any
    // change gives each request and each response wait its own full budget.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake arriving in the final watchdog cycle still wins over expiry.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_bi == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus_ack_i && bus_resp_i) begin
                    capture = 1'b1;
                    state_d = WR_REQ;
                end else if (bus_ack_i) begin
                    state_d = RD_WAIT;
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            RD_WAIT: begin
                if (bus_resp_i) begin
                    capture = 1'b1;
                    state_d = WR_REQ;
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                if (bus_ack_i) begin
                    advance = 1'b1;
                    state_d = NEXT;
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            NEXT: begin
                state_d = ((words_q == len_q) || abort_i) ? DONE : RD_REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                src_q   <= src_addr_bi & ~32'h3;
                dst_q   <= dst_addr_bi & ~32'h3;
                len_q   <= len_bi;
                words_q <= '0;
                err_q   <= 1'b0;
            end
            if (capture) begin
                data_q <= bus_rdata_bi;
            end
            if (advance) begin
                src_q   <= src_q + WORD_BYTES;
                dst_q   <= dst_q + WORD_BYTES;
                words_q <= words_q + LEN_W'(1);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Bus outputs decode straight from the state register, so an asynchronous
    // reset drops the request in the same instant.
    assign bus_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus_we_o     = (state_q == WR_REQ);
    assign bus_addr_bo  = (state_q == RD_REQ) ? src_q :
                          (state_q == WR_REQ) ? dst_q : 32'h0;
    assign bus_be_bo    = bus_req_o ? BE_FULL : 4'h0;
    assign bus_wdata_bo = bus_we_o ? data_q : 32'h0;

    assign busy_o   = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                      (state_q == WR_REQ) || (state_q == NEXT);
    assign done_o   = (state_q == DONE);
    assign err_o    = err_q;
    assign words_bo = words_q;

endmodule

// File: tb/tb_bus_copy_master.sv
module tb_bus_copy_master;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk_i = 1'b0;
    logic             arst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      src_addr_bi = '0;
    logic [31:0]      dst_addr_bi = '0;
    logic [LEN_W-1:0] len_bi = '0;
    logic             abort_i = 1'b0;
    logic             busy_o, done_o, err_o;
    logic [LEN_W-1:0] words_bo;
    logic             bus_req_o, bus_we_o;
    logic [31:0]      bus_addr_bo, bus_wdata_bo;
    logic [3:0]       bus_be_bo;
    logic             bus_ack_i = 1'b0;
    logic             bus_resp_i = 1'b0;
    logic [31:0]      bus_rdata_bi = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    bus_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .start_i(start_i),
        .src_addr_bi(src_addr_bi), .dst_addr_bi(dst_addr_bi), .len_bi(len_bi),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .words_bo(words_bo), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_bo(bus_addr_bo), .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
        .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
    );

    always #5 clk_i = ~clk_i;

    // Responder configuration (written only by the test sequence)
    int          ack_delay = 0;
    bit          same_resp = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    int          drop_rd = -1;
    int          late_req = 0;

    // Responder / monitor state (written only by the always blocks)
    int          late_done = 0;
    int          wait_cnt = 0;
    bit          resp_pending = 1'b0;
    logic [31:0] pend_data = '0;
    int          rd_count = 0;
    int          log_n = 0;
    bit          log_we [0:255];
    logic [31:0] log_addr [0:255];
    logic [31:0] log_data [0:255];
    int          instab = 0, be_bad = 0, req_cycles = 0, busy_cycles = 0;
    int          idle_busy = 0, done_cnt = 0;
    bit          prev_wait = 1'b0;
    logic [64:0] prev_req = '0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return ovr_en ? ovr_val : (a ^ 32'hCAFE_0000);
    endfunction

    // Drive responses for the coming rising edge from the settled request.
    always @(negedge clk_i) begin
        bus_ack_i    = 1'b0;
        bus_resp_i   = 1'b0;
        bus_rdata_bi = 32'h0;
        if (resp_pending) begin
            bus_resp_i   = 1'b1;
            bus_rdata_bi = pend_data;
        end else if (late_done != late_req) begin
            bus_resp_i   = 1'b1;
            bus_rdata_bi = 32'h1111_2222;
            late_done++;
        end
        if (bus_req_o && wait_cnt >= ack_delay) begin
            bus_ack_i = 1'b1;
            if (!bus_we_o && same_resp) begin
                bus_resp_i   = 1'b1;
                bus_rdata_bi = rd_val(bus_addr_bo);
            end
        end
    end

    always @(posedge clk_i) begin
        if (bus_resp_i) resp_pending = 1'b0;
        if (bus_req_o && prev_wait && ({bus_we_o, bus_addr_bo, bus_wdata_bo} != prev_req)) instab++;
        prev_wait = bus_req_o && !bus_ack_i;
        prev_req  = {bus_we_o, bus_addr_bo, bus_wdata_bo};
        if (bus_req_o && bus_ack_i) begin
            if (log_n < 256) begin
                log_we[log_n]   = bus_we_o;
                log_addr[log_n] = bus_addr_bo;
                log_data[log_n] = bus_wdata_bo;
            end
            log_n++;
            if (!bus_we_o) begin
                rd_count++;
                if (!same_resp && rd_count != drop_rd) begin
                    resp_pending = 1'b1;
                    pend_data    = rd_val(bus_addr_bo);
                end
            end
            wait_cnt = 0;
        end else if (bus_req_o) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        if (bus_req_o) req_cycles++;
        if (bus_be_bo !== (bus_req_o ? 4'hF : 4'h0)) be_bad++;
        if (busy_o) busy_cycles++;
        if (busy_o && !bus_req_o) idle_busy++;
        if (done_o) done_cnt++;
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk_i);
        src_addr_bi = s;
        dst_addr_bi = d;
        len_bi      = l;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        @(negedge clk_i);
        total_cnt++;
        if (done_cnt == d0) $display("FAIL %s_done: done_o not seen within %0d cycles", nm, budget);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if ({busy_o, done_o, err_o, words_bo, bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b words=%0d req=%b addr=%h be=%h, all required 0",
                     busy_o, done_o, err_o, words_bo, bus_req_o, bus_addr_bo, bus_be_bo);
        else pass_cnt++;
        @(negedge clk_i);
        arst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total_cnt++;
        if ({busy_o, done_o, bus_req_o} !== 3'b000)
            $display("FAIL reset_idle: busy=%b done=%b req=%b, required 000", busy_o, done_o, bus_req_o);
        else pass_cnt++;
    endtask

    task automatic test_basic_copy();
        int b = log_n;
        int d0 = done_cnt;
        int i0 = instab;
        logic [64:0] exp_e, got_e;
        do_start(32'h100, 32'h200, 3);
        wait_done(100, "basic");
        total_cnt++;
        if (log_n - b !== 6) $display("FAIL basic_count: transactions=%0d required 6", log_n - b);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_e = {1'b0, 32'h100 + 32'(4 * (i / 2)), 32'h0};
            else            exp_e = {1'b1, 32'h200 + 32'(4 * (i / 2)), 32'hCAFE_0100 + 32'(4 * (i / 2))};
            got_e = {log_we[b + i], log_addr[b + i], (i % 2 == 0) ? 32'h0 : log_data[b + i]};
            total_cnt++;
            if (got_e !== exp_e) $display("FAIL basic_txn%0d: got %h required %h", i, got_e, exp_e);
            else pass_cnt++;
        end
        total_cnt++;
        if ({words_bo, err_o} !== {16'd3, 1'b0}) $display("FAIL basic_status: words=%0d err=%b required 3/0", words_bo, err_o);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulse: pulses=%0d required 1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (instab - i0 !== 0 || be_bad !== 0) $display("FAIL basic_bus_rules: instab=%0d be_bad=%0d required 0/0", instab - i0, be_bad);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int r0 = req_cycles;
        int b0 = busy_cycles;
        int d0 = done_cnt;
        do_start(32'h100, 32'h200, 0);
        wait_done(10, "len0");
        repeat (2) @(negedge clk_i);
        total_cnt++;
        if (req_cycles - r0 !== 0) $display("FAIL len0_req: req cycles=%0d required 0", req_cycles - r0);
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles - b0 !== 0) $display("FAIL len0_busy: busy cycles=%0d required 0", busy_cycles - b0);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL len0_done_pulse: pulses=%0d required 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_ack_wait();
        int b = log_n;
        int r0 = req_cycles;
        int i0 = instab;
        ack_delay = 5;
        do_start(32'h20, 32'h40, 1);
        wait_done(100, "ackwait");
        ack_delay = 0;
        total_cnt++;
        if (log_n - b !== 2) $display("FAIL ackwait_count: transactions=%0d required 2", log_n - b);
        else pass_cnt++;
        total_cnt++;
        if ({log_we[b + 1], log_addr[b + 1], log_data[b + 1]} !== {1'b1, 32'h40, 32'hCAFE_0020})
            $display("FAIL ackwait_write: we=%b addr=%h data=%h required 1/00000040/cafe0020",
                     log_we[b + 1], log_addr[b + 1], log_data[b + 1]);
        else pass_cnt++;
        total_cnt++;
        if (req_cycles - r0 !== 12) $display("FAIL ackwait_req_cycles: got %0d required 12", req_cycles - r0);
        else pass_cnt++;
        total_cnt++;
        if (instab - i0 !== 0) $display("FAIL ackwait_stable: changes while waiting=%0d required 0", instab - i0);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle_resp();
        int b = log_n;
        int r0 = req_cycles;
        int ib0 = idle_busy;
        same_resp = 1'b1;
        ovr_en    = 1'b1;
        ovr_val   = 32'hDEAD_BEEF;
        do_start(32'h1000, 32'h300, 1);
        wait_done(50, "same");
        same_resp = 1'b0;
        ovr_en    = 1'b0;
        total_cnt++;
        if ({log_we[b + 1], log_addr[b + 1], log_data[b + 1]} !== {1'b1, 32'h300, 32'hDEAD_BEEF})
            $display("FAIL same_write: we=%b addr=%h data=%h required 1/00000300/deadbeef",
                     log_we[b + 1], log_addr[b + 1], log_data[b + 1]);
        else pass_cnt++;
        total_cnt++;
        if (req_cycles - r0 !== 2) $display("FAIL same_req_cycles: got %0d required 2", req_cycles - r0);
        else pass_cnt++;
        total_cnt++;
        if (idle_busy - ib0 !== 1) $display("FAIL same_no_rdwait: busy-without-req cycles=%0d required 1", idle_busy - ib0);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int b = log_n;
        int n0;
        drop_rd = rd_count + 2;
        do_start(32'h700, 32'h800, 4);
        wait_done(200, "timeout");
        drop_rd = -1;
        total_cnt++;
        if ({err_o, words_bo, bus_req_o} !== {1'b1, 16'd1, 1'b0})
            $display("FAIL timeout_status: err=%b words=%0d req=%b required 1/1/0", err_o, words_bo, bus_req_o);
        else pass_cnt++;
        total_cnt++;
        if (log_n - b !== 3) $display("FAIL timeout_count: transactions=%0d required 3", log_n - b);
        else pass_cnt++;
        n0 = log_n;
        late_req++;
        repeat (4) @(negedge clk_i);
        total_cnt++;
        if ({err_o, words_bo, busy_o, done_o} !== {1'b1, 16'd1, 1'b0, 1'b0} || log_n != n0)
            $display("FAIL timeout_late_resp: err=%b words=%0d busy=%b done=%b new txns=%0d required 1/1/0/0/0",
                     err_o, words_bo, busy_o, done_o, log_n - n0);
        else pass_cnt++;
        do_start(32'h700, 32'h800, 1);
        total_cnt++;
        if (err_o !== 1'b0) $display("FAIL timeout_err_clear: err=%b required 0", err_o);
        else pass_cnt++;
        wait_done(50, "timeout_restart");
        total_cnt++;
        if ({err_o, words_bo} !== {1'b0, 16'd1}) $display("FAIL timeout_restart: err=%b words=%0d required 0/1", err_o, words_bo);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int b = log_n;
        do_start(32'hFFFF_FFFC, 32'h403, 2);
        wait_done(50, "wrap");
        total_cnt++;
        if ({log_we[b + 2], log_addr[b + 2]} !== {1'b0, 32'h0})
            $display("FAIL wrap_read2: we=%b addr=%h required 0/00000000", log_we[b + 2], log_addr[b + 2]);
        else pass_cnt++;
        total_cnt++;
        if ({log_addr[b + 1], log_data[b + 1], log_addr[b + 3], log_data[b + 3]} !==
            {32'h400, 32'h3501_FFFC, 32'h404, 32'hCAFE_0000})
            $display("FAIL wrap_writes: %h/%h %h/%h required 00000400/3501fffc 00000404/cafe0000",
                     log_addr[b + 1], log_data[b + 1], log_addr[b + 3], log_data[b + 3]);
        else pass_cnt++;
        total_cnt++;
        if (words_bo !== 16'd2) $display("FAIL wrap_words: words=%0d required 2", words_bo);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int b = log_n;
        abort_i = 1'b1;
        do_start(32'h900, 32'hA00, 10);
        wait_done(100, "abort");
        abort_i = 1'b0;
        total_cnt++;
        if ({words_bo, err_o} !== {16'd1, 1'b0}) $display("FAIL abort_status: words=%0d err=%b required 1/0", words_bo, err_o);
        else pass_cnt++;
        total_cnt++;
        if (log_n - b !== 2) $display("FAIL abort_count: transactions=%0d required 2", log_n - b);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int b = log_n;
        int n = 0;
        ack_delay = 3;
        do_start(32'h500, 32'h600, 2);
        while (!(bus_req_o && bus_we_o) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        total_cnt++;
        if (!(bus_req_o && bus_we_o)) $display("FAIL arst_reach_wr: write request not seen within 50 cycles");
        else pass_cnt++;
        #2 arst_n_i = 1'b0;
        #1;
        total_cnt++;
        if ({busy_o, done_o, err_o, words_bo, bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo} !== '0)
            $display("FAIL arst_outputs: busy=%b req=%b we=%b addr=%h be=%h wdata=%h, all required 0",
                     busy_o, bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo);
        else pass_cnt++;
        @(negedge clk_i);
        arst_n_i  = 1'b1;
        ack_delay = 0;
        @(negedge clk_i);
        total_cnt++;
        if (log_n - b !== 1 || busy_o !== 1'b0) $display("FAIL arst_idle: txns=%0d busy=%b required 1/0", log_n - b, busy_o);
        else pass_cnt++;
        b = log_n;
        do_start(32'hB00, 32'hC00, 1);
        wait_done(50, "arst_after");
        total_cnt++;
        if ({words_bo, log_addr[b + 1], log_data[b + 1]} !== {16'd1, 32'hC00, 32'hCAFE_0B00})
            $display("FAIL arst_after_copy: words=%0d addr=%h data=%h required 1/00000c00/cafe0b00",
                     words_bo, log_addr[b + 1], log_data[b + 1]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_ack_wait();
        test_same_cycle_resp();
        test_timeout();
        test_wrap();
        test_abort();
        test_async_reset();
        repeat (2) @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
